lmsm_sequencer: RTL and testbench
=================================

// Module: lmsm_sequencer
// PURPOSE
//  Multicycle controller for load-multiple (LM) and store-multiple (SM) instructions.
//  It drives the register file's read port 1 and write port 1 from the datapath side.
//  It walks an 8-bit register mask in ascending order (R0..R7) and moves one register per memory handshake.
//  Sits between the main control FSM (start/done) and the register file and data memory.
// PARAMETERS
//  DATA_W       16   data and memory address width
//  RADDR_W      3    register address width
//  NREG         8    number of registers; equals the mask width
//  TIMEOUT_CYC  255  max wait cycles for In_mem_ready (used only with LMSM_TIMEOUT_EN)
// PORTS
//  In_clock            in   1       single clock; all state changes on its rising edge
//  In_reset            in   1       synchronous, active-high reset
//  In_start            in   1       start pulse; sampled only in IDLE
//  In_is_store         in   1       1 = SM (RF->mem), 0 = LM (mem->RF); latched at start
//  In_reg_mask         in   NREG    bit i set = transfer Ri; latched at start
//  In_base_addr        in   DATA_W  first memory address; latched at start
//  Out_busy            out  1       high from the cycle after start until DONE exits
//  Out_done            out  1       1-cycle completion pulse
//  Out_RF_Read_addr1   out  RADDR_W SM source register
//  In_RF_Read_data1    in   DATA_W  RF async read data
//  Out_RF_Write_addr1  out  RADDR_W LM destination register
//  Out_RF_Write_data1  out  DATA_W  LM write data (registered)
//  Out_RF_Write_en_1   out  1       LM write strobe
//  Out_mem_addr        out  DATA_W  memory address
//  Out_mem_wdata       out  DATA_W  SM store data
//  Out_mem_wr_en       out  1       memory write request
//  Out_mem_rd_en       out  1       memory read request
//  In_mem_rdata        in   DATA_W  memory read data; valid with In_mem_ready
//  In_mem_ready        in   1       memory completes the current request this cycle
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (busy, done, enables, addresses, data); latched mask and address cleared.
//  Reset mid-transfer: aborts immediately; no further RF write or mem request; done is not pulsed.
//  States:
//  - IDLE: if In_start=1, latch mask/base/is_store. Nonzero mask -> ACCESS. Zero mask -> DONE.
//  - ACCESS:
//    - cur = lowest set bit of the remaining mask; Out_mem_addr = current address.
//    - SM: Out_RF_Read_addr1=cur, Out_mem_wdata=In_RF_Read_data1 (combinational), Out_mem_wr_en=1.
//    - LM: Out_mem_rd_en=1.
//    - Request is held stable until In_mem_ready=1.
//    - On ready: clear bit cur; address+1 (wraps 0xFFFF->0x0000).
//    - SM on ready: next state is ACCESS, or DONE if the mask is now empty.
//    - LM on ready: capture In_mem_rdata and cur, then go to WB.
//  - WB (LM only): Out_RF_Write_en_1=1 for exactly 1 cycle with the captured addr/data; then ACCESS, or DONE if the mask is empty.
//  - DONE: Out_done=1 for 1 cycle -> IDLE.
//  Latency with ready tied high and popcount=k: SM = 1+k+1 cycles start->done; LM = 1+2k+1.
//  In_start while not IDLE is ignored. Mask/base changes after start have no effect.
//  Outside their states, all enables are 0 and addresses/data hold 0.
// CONFIGURATION
//  LMSM_TIMEOUT_EN defined:
//  - adds output Out_error (1 bit) and a wait counter, cleared on each ACCESS entry.
//  - If the wait reaches TIMEOUT_CYC cycles without ready: drop the request, pulse Out_error and Out_done together for 1 cycle, return to IDLE.
//  - The remaining mask is discarded.
//  Not defined: no Out_error port; ACCESS waits indefinitely for In_mem_ready.
// STRUCTURE
//  lmsm_pkg: state encoding (IDLE, ACCESS, WB, DONE), DATA_W/RADDR_W/NREG constants.
//  Sub-module lsb_priority_enc8: 8-bit mask -> 3-bit index of the lowest set bit, plus a valid flag.
//  Top: FSM, mask/address/capture registers, optional timeout counter.
// TESTING
//  - SM: mask=8'h05, base=16'h0040, ready=1, R0=16'h1111, R2=16'h2222 -> writes 1111@0040, 2222@0041; done 4 cycles after start.
//  - LM: mask=8'h82, base=16'h0100, mem[100]=16'hAAAA, mem[101]=16'hBBBB -> R1=AAAA, then R7=BBBB; exactly 2 write_en pulses.
//  - Zero mask: start with mask=8'h00 -> no mem/RF enables; done pulses 2 cycles after start.
//  - Wrap and stall: base=16'hFFFF, mask=8'h03, ready low 3 cycles per request -> addresses FFFF then 0000; request held stable during stalls.
//  - Reset mid-LM: assert In_reset during the first WB cycle of mask 8'hFF -> no further writes; all outputs 0 next cycle; a new start works.
//  - LMSM_TIMEOUT_EN with TIMEOUT_CYC=4 and ready stuck low -> error and done pulse together; state returns to IDLE.

Source files
------------

// File: rtl/lmsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lmsm_pkg : shared widths and FSM encoding for the LM/SM sequencer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lmsm_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;
    localparam int NREG    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lmsm_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lmsm_sequencer_if : control, register-file and memory signals of the |
// | LM/SM sequencer; Out_error exists only with LMSM_TIMEOUT_EN. Rev 1.0 |
// +----------------------------------------------------------------------+
interface lmsm_sequencer_if;
    import lmsm_pkg::*;

    logic                In_start;
    logic                In_is_store;
    logic [NREG-1:0]     In_reg_mask;
    logic [DATA_W-1:0]   In_base_addr;
    logic                Out_busy;
    logic                Out_done;
    logic [RADDR_W-1:0]  Out_RF_Read_addr1;
    logic [DATA_W-1:0]   In_RF_Read_data1;
    logic [RADDR_W-1:0]  Out_RF_Write_addr1;
    logic [DATA_W-1:0]   Out_RF_Write_data1;
    logic                Out_RF_Write_en_1;
    logic [DATA_W-1:0]   Out_mem_addr;
    logic [DATA_W-1:0]   Out_mem_wdata;
    logic                Out_mem_wr_en;
    logic                Out_mem_rd_en;
    logic [DATA_W-1:0]   In_mem_rdata;
    logic                In_mem_ready;
`ifdef LMSM_TIMEOUT_EN
    logic                Out_error;
`endif

    modport master (
        input  In_start, In_is_store, In_reg_mask, In_base_addr,
        input  In_RF_Read_data1, In_mem_rdata, In_mem_ready,
        output Out_busy, Out_done, Out_RF_Read_addr1,
        output Out_RF_Write_addr1, Out_RF_Write_data1, Out_RF_Write_en_1,
`ifdef LMSM_TIMEOUT_EN
        output Out_error,
`endif
        output Out_mem_addr, Out_mem_wdata, Out_mem_wr_en, Out_mem_rd_en
    );

    modport slave (
        output In_start, In_is_store, In_reg_mask, In_base_addr,
        output In_RF_Read_data1, In_mem_rdata, In_mem_ready,
        input  Out_busy, Out_done, Out_RF_Read_addr1,
        input  Out_RF_Write_addr1, Out_RF_Write_data1, Out_RF_Write_en_1,
`ifdef LMSM_TIMEOUT_EN
        input  Out_error,
`endif
        input  Out_mem_addr, Out_mem_wdata, Out_mem_wr_en, Out_mem_rd_en
    );

endinterface
`default_nettype wire

// File: rtl/lsb_priority_enc8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsb_priority_enc8 : index of the lowest set bit of an 8-bit mask     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsb_priority_enc8 (
    input  wire logic [7:0] i_mask,
    output logic      [2:0] o_idx,
    output logic            o_valid
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        o_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = 3'(i);
            end
        end
    end

    assign o_valid = |i_mask;

endmodule
`default_nettype wire

// File: rtl/lmsm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lmsm_sequencer : walks a register mask R0..R7, one memory handshake  |
// | per register. LMSM_TIMEOUT_EN adds a ready timeout and Out_error.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lmsm_sequencer
`ifdef LMSM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = 255
)
`endif
(
    input  wire logic            In_clock,
    input  wire logic            In_reset,
    lmsm_sequencer_if.master     bus
);
    import lmsm_pkg::*;

    state_t              state_q, state_d;
    logic [NREG-1:0]     mask_q, mask_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic                store_q, store_d;
    logic [RADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;

    logic [RADDR_W-1:0]  w_cur_idx;
    logic                w_cur_valid;
    logic [NREG-1:0]     w_cur_onehot;
    logic [NREG-1:0]     w_mask_left;
    logic                w_req;
    logic                w_wb;

`ifdef LMSM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    lsb_priority_enc8 u_enc (
        .i_mask  (mask_q),
        .o_idx   (w_cur_idx),
        .o_valid (w_cur_valid)
    );

    assign w_cur_onehot = NREG'(1) << w_cur_idx;
    assign w_mask_left  = mask_q & ~w_cur_onehot;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        store_d   = store_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
`ifdef LMSM_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.In_start) begin
                    mask_d  = bus.In_reg_mask;
                    addr_d  = bus.In_base_addr;
                    store_d = bus.In_is_store;
                    state_d = (|bus.In_reg_mask) ? ST_ACCESS : ST_DONE;
`ifdef LMSM_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_ACCESS: begin
                if (w_cur_valid && bus.In_mem_ready) begin
                    mask_d = w_mask_left;
                    addr_d = addr_q + 1'b1;
                    if (store_q) begin
                        state_d = (|w_mask_left) ? ST_ACCESS : ST_DONE;
                    end else begin
                        wb_addr_d = w_cur_idx;
                        wb_data_d = bus.In_mem_rdata;
                        state_d   = ST_WB;
                    end
`ifdef LMSM_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Give up: drop the request and discard the rest of the mask.
                    mask_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_WB: begin
                state_d = (|mask_q) ? ST_ACCESS : ST_DONE;
`ifdef LMSM_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef LMSM_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge In_clock) begin
        if (In_reset) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            addr_q    <= '0;
            store_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
`ifdef LMSM_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
`ifdef LMSM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Every output decodes from registered state; SM store data passes straight from the RF.
    assign w_req = (state_q == ST_ACCESS) && w_cur_valid;
    assign w_wb  = (state_q == ST_WB);

    assign bus.Out_busy           = (state_q != ST_IDLE);
    assign bus.Out_done           = (state_q == ST_DONE);
    assign bus.Out_mem_addr       = w_req ? addr_q : '0;
    assign bus.Out_mem_wr_en      = w_req && store_q;
    assign bus.Out_mem_rd_en      = w_req && !store_q;
    assign bus.Out_RF_Read_addr1  = (w_req && store_q) ? w_cur_idx : '0;
    assign bus.Out_mem_wdata      = (w_req && store_q) ? bus.In_RF_Read_data1 : '0;
    assign bus.Out_RF_Write_en_1  = w_wb;
    assign bus.Out_RF_Write_addr1 = w_wb ? wb_addr_q : '0;
    assign bus.Out_RF_Write_data1 = w_wb ? wb_data_q : '0;
`ifdef LMSM_TIMEOUT_EN
    assign bus.Out_error          = (state_q == ST_DONE) && err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lmsm_sequencer : directed and random LM/SM transfers against a    |
// | per-cycle event timeline built from the transfer rules. Rev 1.0      |
// +----------------------------------------------------------------------+
module tb_lmsm_sequencer;

    logic clk;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    int   wb_seen = 0;

    bit [15:0] rf_m  [8];
    bit [15:0] mem_m [0:65535];

    typedef struct {
        bit          wb;
        logic [15:0] addr;
        logic [2:0]  rg;
        bit          rdy;
    } ev_t;

    lmsm_sequencer_if bus ();

    assign bus.In_RF_Read_data1 = rf_m[bus.Out_RF_Read_addr1];

`ifdef LMSM_TIMEOUT_EN
    localparam int STALL_MAX = 2;
    lmsm_sequencer #(.TIMEOUT_CYC(4)) dut (.In_clock(clk), .In_reset(rst), .bus(bus));
`else
    localparam int STALL_MAX = 3;
    lmsm_sequencer dut (.In_clock(clk), .In_reset(rst), .bus(bus));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic chk_all(input string tag, input logic busy, input logic done,
                           input logic wr, input logic rd, input logic [15:0] maddr,
                           input logic [15:0] mwdat, input logic [2:0] raddr,
                           input logic we, input logic [2:0] waddr, input logic [15:0] wdat,
                           input logic err);
        chk({tag, ".busy"},   32'(bus.Out_busy),           32'(busy));
        chk({tag, ".done"},   32'(bus.Out_done),           32'(done));
        chk({tag, ".wr_en"},  32'(bus.Out_mem_wr_en),      32'(wr));
        chk({tag, ".rd_en"},  32'(bus.Out_mem_rd_en),      32'(rd));
        chk({tag, ".maddr"},  32'(bus.Out_mem_addr),       32'(maddr));
        chk({tag, ".mwdata"}, 32'(bus.Out_mem_wdata),      32'(mwdat));
        chk({tag, ".raddr1"}, 32'(bus.Out_RF_Read_addr1),  32'(raddr));
        chk({tag, ".we1"},    32'(bus.Out_RF_Write_en_1),  32'(we));
        chk({tag, ".waddr1"}, 32'(bus.Out_RF_Write_addr1), 32'(waddr));
        chk({tag, ".wdata1"}, 32'(bus.Out_RF_Write_data1), 32'(wdat));
`ifdef LMSM_TIMEOUT_EN
        chk({tag, ".error"},  32'(bus.Out_error),          32'(err));
`else
        if (err) chk({tag, ".error_unexpected"}, 32'(err), 32'(0));
`endif
        if (bus.Out_RF_Write_en_1 === 1'b1) wb_seen++;
    endtask

    task automatic chk_idle(input string tag);
        chk_all(tag, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0, 0, 3'd0, 16'h0, 0);
    endtask

    // Called just after a negedge. stall<0 means random stalls up to smax.
    // Returns the start-relative cycle in which done is expected.
    task automatic run_txn(input string tag, input bit st, input logic [7:0] mask,
                           input logic [15:0] base, input int stall, input int smax,
                           input bit fill_mem, input bit reset_at_wb, input bit to_mode,
                           output int done_c);
        ev_t tl[$];
        int  n = 0;
        ev_t ev;
        bit  aborted = 0;
        if (to_mode) begin
            for (int k = 0; k < 4; k++) tl.push_back('{0, base, 3'd0, 1'b0});
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) begin
                    logic [15:0] a;
                    int s;
                    a = base + 16'(n);
                    n++;
                    s = (stall >= 0) ? stall : int'($urandom_range(smax, 0));
                    if (fill_mem && !st) mem_m[a] = 16'($urandom);
                    for (int k = 0; k <= s; k++) tl.push_back('{0, a, 3'(i), k == s});
                    if (!st) tl.push_back('{1, a, 3'(i), 1'b0});
                end
            end
        end
        done_c = 1 + tl.size();

        bus.In_start     = 1'b1;
        bus.In_is_store  = st;
        bus.In_reg_mask  = mask;
        bus.In_base_addr = base;
        bus.In_mem_ready = 1'b0;
        for (int c = 1; c <= done_c + 1 && !aborted; c++) begin
            @(negedge clk);
            bus.In_start     = 1'b0;
            bus.In_is_store  = 1'($urandom);
            bus.In_reg_mask  = 8'($urandom);
            bus.In_base_addr = 16'($urandom);
            bus.In_mem_ready = 1'b0;
            bus.In_mem_rdata = 16'($urandom);
            if (c <= tl.size()) begin
                ev = tl[c-1];
                if (!ev.wb) begin
                    chk_all(tag, 1, 0, st, !st, ev.addr, st ? rf_m[ev.rg] : 16'h0,
                            st ? ev.rg : 3'd0, 0, 3'd0, 16'h0, 0);
                    bus.In_mem_ready = ev.rdy;
                    if (ev.rdy) begin
                        if (st) mem_m[ev.addr] = rf_m[ev.rg];
                        else    bus.In_mem_rdata = mem_m[ev.addr];
                    end
                end else begin
                    chk_all(tag, 1, 0, 0, 0, 16'h0, 16'h0, 3'd0, 1, ev.rg, mem_m[ev.addr], 0);
                    rf_m[ev.rg] = mem_m[ev.addr];
                    if (reset_at_wb) begin
                        rst = 1'b1;
                        @(negedge clk);
                        chk_idle({tag, ".in_reset"});
                        rst = 1'b0;
                        @(negedge clk);
                        chk_idle({tag, ".after_reset"});
                        aborted = 1;
                    end
                end
            end else if (c == done_c) begin
                chk_all(tag, 1, 1, 0, 0, 16'h0, 16'h0, 3'd0, 0, 3'd0, 16'h0, to_mode);
            end else begin
                chk_idle({tag, ".post"});
            end
        end
    endtask

    initial begin
        int dc;
        int w0;
        rst              = 1'b1;
        bus.In_start     = 1'b0;
        bus.In_is_store  = 1'b0;
        bus.In_reg_mask  = 8'h00;
        bus.In_base_addr = 16'h0000;
        bus.In_mem_ready = 1'b0;
        bus.In_mem_rdata = 16'h0000;
        for (int i = 0; i < 8; i++) rf_m[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        // SM two registers, ready tied high
        rf_m[0] = 16'h1111;
        rf_m[2] = 16'h2222;
        run_txn("sm05", 1, 8'h05, 16'h0040, 0, 0, 0, 0, 0, dc);
        chk("sm05.done_cycle", 32'(dc), 32'd3);
        chk("sm05.mem40", 32'(mem_m[16'h0040]), 32'h1111);
        chk("sm05.mem41", 32'(mem_m[16'h0041]), 32'h2222);

        // LM R1 and R7
        mem_m[16'h0100] = 16'hAAAA;
        mem_m[16'h0101] = 16'hBBBB;
        w0 = wb_seen;
        run_txn("lm82", 0, 8'h82, 16'h0100, 0, 0, 0, 0, 0, dc);
        chk("lm82.done_cycle", 32'(dc), 32'd5);
        chk("lm82.r1", 32'(rf_m[1]), 32'hAAAA);
        chk("lm82.r7", 32'(rf_m[7]), 32'hBBBB);
        chk("lm82.wb_pulses", 32'(wb_seen - w0), 32'd2);

        // Empty mask goes straight to done
        run_txn("zero", 1, 8'h00, 16'h1234, 0, 0, 0, 0, 0, dc);
        chk("zero.done_cycle", 32'(dc), 32'd1);

        // Address wrap with three stall cycles per request
        rf_m[0] = 16'h0A0A;
        rf_m[1] = 16'hB0B0;
        run_txn("wrap", 1, 8'h03, 16'hFFFF, 3, 0, 0, 0, 0, dc);
        chk("wrap.done_cycle", 32'(dc), 32'd9);
        chk("wrap.memFFFF", 32'(mem_m[16'hFFFF]), 32'h0A0A);
        chk("wrap.mem0000", 32'(mem_m[16'h0000]), 32'hB0B0);

        // Reset during the first write-back of a full LM
        w0 = wb_seen;
        run_txn("rstlm", 0, 8'hFF, 16'h0200, 0, 0, 1, 1, 0, dc);
        chk("rstlm.wb_pulses", 32'(wb_seen - w0), 32'd1);
        run_txn("restart", 1, 8'h18, 16'h0300, -1, STALL_MAX, 0, 0, 0, dc);

        for (int t = 0; t < 40; t++) begin
            run_txn($sformatf("rnd%0d", t), 1'($urandom), 8'($urandom), 16'($urandom),
                    -1, STALL_MAX, 1, 0, 0, dc);
            repeat ($urandom_range(2, 0)) begin
                @(negedge clk);
                chk_idle("gap");
            end
        end

`ifdef LMSM_TIMEOUT_EN
        run_txn("timeout", 0, 8'h0F, 16'h0500, 0, 0, 0, 0, 1, dc);
        chk("timeout.done_cycle", 32'(dc), 32'd5);
        run_txn("after_to", 0, 8'h01, 16'h0600, 0, 0, 1, 0, 0, dc);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
